// File: rtl/bru_pkg.sv
// Shared types and BTB command encodings for the branch resolve unit.
package bru_pkg;

    localparam int BRU_XLEN = 32;

    localparam logic [1:0] BTB_NOP    = 2'b00;
    localparam logic [1:0] BTB_UPDATE = 2'b10;
    localparam logic [1:0] BTB_INVAL  = 2'b01;

    typedef struct packed {
        logic                valid;
        logic [BRU_XLEN-1:0] pc;
        logic                hit;
        logic [BRU_XLEN-1:0] pre_pc;
    } pred_meta_t;

endpackage

// File: rtl/bru_meta_reg.sv
// One pipeline stage of prediction metadata; flush clears valid even while stalled.
module bru_meta_reg
    import bru_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       flush,
    input  pred_meta_t meta_in,
    output pred_meta_t meta_out
);

    pred_meta_t meta_d;
    pred_meta_t meta_q;

    always_comb begin
        meta_d = meta_q;
        if (!stall) begin
            meta_d = meta_in;
        end
        if (flush) begin
            meta_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
        end else begin
            meta_q <= meta_d;
        end
    end

    assign meta_out = meta_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries BTB predictions to EX, resolves them, and drives redirect/flush,
// BTB update commands and prediction statistics.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN  = BRU_XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             if_btb_hit,
    input  logic [XLEN-1:0]  if_pre_pc,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [1:0]       btb_cmd,
    output logic [XLEN-1:0]  btb_update_pc,
    output logic [XLEN-1:0]  btb_update_target,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    pred_meta_t if_meta;
    pred_meta_t id_meta;
    pred_meta_t ex_meta;

    logic             resolve;
    logic             mis;
    logic [1:0]       cmd_calc;
    logic [XLEN-1:0]  target_calc;
    logic [XLEN-1:0]  seq_pc;

    logic             done_d, done_q;
    logic [1:0]       cmd_d, cmd_q;
    logic [XLEN-1:0]  upd_pc_d, upd_pc_q;
    logic [XLEN-1:0]  upd_tgt_d, upd_tgt_q;
    logic [CNT_W-1:0] br_cnt_d, br_cnt_q;
    logic [CNT_W-1:0] mis_cnt_d, mis_cnt_q;

    always_comb begin
        if_meta.valid  = 1'b1;
        if_meta.pc     = if_pc;
        if_meta.hit    = if_btb_hit;
        if_meta.pre_pc = if_pre_pc;
    end

    bru_meta_reg u_id_reg (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .meta_in  (if_meta),
        .meta_out (id_meta)
    );

    bru_meta_reg u_ex_reg (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .meta_in  (id_meta),
        .meta_out (ex_meta)
    );

    assign resolve = ex_meta.valid && !done_q;
    assign seq_pc  = ex_meta.pc + XLEN'(4);

    always_comb begin
        mis         = 1'b0;
        cmd_calc    = BTB_NOP;
        target_calc = ex_target;
        if (ex_is_branch) begin
            if (ex_meta.hit && ex_taken && (ex_target != ex_meta.pre_pc)) begin
                mis      = 1'b1;
                cmd_calc = BTB_UPDATE;
            end else if (ex_meta.hit && !ex_taken) begin
                mis         = 1'b1;
                cmd_calc    = BTB_INVAL;
                target_calc = seq_pc;
            end else if (!ex_meta.hit && ex_taken) begin
                mis      = 1'b1;
                cmd_calc = BTB_UPDATE;
            end
        end else if (ex_meta.hit) begin
            // a BTB hit on a non-branch is an alias: drop the entry, fall through
            mis         = 1'b1;
            cmd_calc    = BTB_INVAL;
            target_calc = seq_pc;
        end
    end

    assign redirect    = resolve && mis;
    assign redirect_pc = target_calc;
    assign flush       = redirect;

    always_comb begin
        done_d    = done_q;
        cmd_d     = BTB_NOP;
        upd_pc_d  = upd_pc_q;
        upd_tgt_d = upd_tgt_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (resolve) begin
            done_d = 1'b1;
            cmd_d  = cmd_calc;
            if (cmd_calc != BTB_NOP) begin
                upd_pc_d  = ex_meta.pc;
                upd_tgt_d = target_calc;
            end
            if (ex_is_branch) begin
                br_cnt_d = br_cnt_q + CNT_W'(1);
            end
            if (mis) begin
                mis_cnt_d = mis_cnt_q + CNT_W'(1);
            end
        end
        // EX loads a fresh record on every unstalled edge
        if (!stall) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q    <= 1'b0;
            cmd_q     <= BTB_NOP;
            upd_pc_q  <= '0;
            upd_tgt_q <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            done_q    <= done_d;
            cmd_q     <= cmd_d;
            upd_pc_q  <= upd_pc_d;
            upd_tgt_q <= upd_tgt_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign btb_cmd           = cmd_q;
    assign btb_update_pc     = upd_pc_q;
    assign btb_update_target = upd_tgt_q;
    assign branch_cnt        = br_cnt_q;
    assign mispredict_cnt    = mis_cnt_q;

endmodule
